// File: rtl/bist_pkg.sv
// Shared types for the BIST failure logger: entry layout, control states.
package bist_pkg;

  localparam int ELEM_WIDTH      = 4;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH  = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] syndrome;
    logic [ELEM_WIDTH-1:0]     element;
  } fail_entry_t;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    ARMED     = 2'd1,
    LOGGING   = 2'd2,
    SATURATED = 2'd3
  } state_t;

endpackage

// File: rtl/fail_log_fifo.sv
// Circular failure log with show-ahead head output.
module fail_log_fifo
  import bist_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int LOG_DEPTH = 8,
  localparam int PW = $clog2(LOG_DEPTH),
  localparam int CW = $clog2(LOG_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic [AW-1:0]         push_addr,
  input  logic [DW-1:0]         push_syndrome,
  input  logic [ELEM_WIDTH-1:0] push_element,
  input  logic                  pop,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic [AW-1:0]         head_addr,
  output logic [DW-1:0]         head_syndrome,
  output logic [ELEM_WIDTH-1:0] head_element
);

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [DW-1:0]         syndrome;
    logic [ELEM_WIDTH-1:0] element;
  } entry_t;

  entry_t        mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  entry_t        head;

  assign empty   = (count == '0);
  assign full    = (count == CW'(LOG_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Gate the head so outputs read zero while empty
  assign head_addr     = empty ? '0 : head.addr;
  assign head_syndrome = empty ? '0 : head.syndrome;
  assign head_element  = empty ? '0 : head.element;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{addr: push_addr,
                       syndrome: push_syndrome,
                       element: push_element};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bist_fail_logger.sv
// BIST failure logger: counters, bitmap, first-fail capture, control FSM.
// Optional same-address/element dedup under FAIL_LOG_DEDUP_EN.
module bist_fail_logger
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int CW = $clog2(LOG_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  session_start,
  input  logic                  err_valid,
  input  logic [ADDR_WIDTH-1:0] err_addr,
  input  logic [DATA_WIDTH-1:0] err_expected,
  input  logic [DATA_WIDTH-1:0] err_actual,
  input  logic [ELEM_WIDTH-1:0] err_element,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_syndrome,
  output logic [ELEM_WIDTH-1:0] rd_element,
  output logic [CW-1:0]         log_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] fail_bitmap,
  output logic                  first_fail_valid,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_MAX - CNT_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic                  clr;
  logic                  ev;
  logic                  dup;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] syndrome;

  assign clr      = rst | session_start;
  assign ev       = err_valid & ~clr;
  assign syndrome = err_expected ^ err_actual;
  assign pop      = rd_valid & rd_ready;
  assign push     = ev & ~dup;
  assign rd_valid = ~empty;

`ifdef FAIL_LOG_DEDUP_EN
  logic                  last_valid;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ELEM_WIDTH-1:0] last_elem;

  assign dup = last_valid
             & (last_addr == err_addr)
             & (last_elem == err_element);

  // Tracks only entries that actually landed in the log
  always_ff @(posedge clk) begin
    if (clr) begin
      last_valid <= 1'b0;
      last_addr  <= '0;
      last_elem  <= '0;
    end else if (push & (~full | pop)) begin
      last_valid <= 1'b1;
      last_addr  <= err_addr;
      last_elem  <= err_element;
    end
  end
`else
  assign dup = 1'b0;
`endif

  fail_log_fifo #(
    .AW        (ADDR_WIDTH),
    .DW        (DATA_WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .clr           (clr),
    .push          (push),
    .push_addr     (err_addr),
    .push_syndrome (syndrome),
    .push_element  (err_element),
    .pop           (pop),
    .empty         (empty),
    .full          (full),
    .count         (log_count),
    .head_addr     (rd_addr),
    .head_syndrome (rd_syndrome),
    .head_element  (rd_element)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      err_count        <= '0;
      fail_bitmap      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_addr  <= '0;
      overflow         <= 1'b0;
    end else if (ev) begin
      if (err_count != CNT_MAX) err_count <= err_count + CNT_WIDTH'(1);
      fail_bitmap <= fail_bitmap | syndrome;
      if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_addr  <= err_addr;
      end
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:     state_d = ev ? LOGGING : ARMED;
      ARMED:     if (ev) state_d = LOGGING;
      LOGGING:   if (ev && err_count == CNT_PRE) state_d = SATURATED;
      SATURATED: state_d = SATURATED;
      default:   state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger (default and CNT_WIDTH=4 instances).
module tb_bist_fail_logger;
  import bist_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        session_start;
  logic        err_valid;
  logic [9:0]  err_addr;
  logic [31:0] err_expected;
  logic [31:0] err_actual;
  logic [3:0]  err_element;
  logic        rd_ready;

  logic        rd_valid;
  logic [9:0]  rd_addr;
  logic [31:0] rd_syndrome;
  logic [3:0]  rd_element;
  logic [3:0]  log_count;
  logic [15:0] err_count;
  logic [31:0] fail_bitmap;
  logic        first_fail_valid;
  logic [9:0]  first_fail_addr;
  logic        overflow;

  logic        rd_valid_4;
  logic [9:0]  rd_addr_4;
  logic [31:0] rd_syndrome_4;
  logic [3:0]  rd_element_4;
  logic [3:0]  log_count_4;
  logic [3:0]  err_count_4;
  logic [31:0] fail_bitmap_4;
  logic        first_fail_valid_4;
  logic [9:0]  first_fail_addr_4;
  logic        overflow_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_fail_logger dut (
    .clk(clk), .rst(rst), .session_start(session_start),
    .err_valid(err_valid), .err_addr(err_addr),
    .err_expected(err_expected), .err_actual(err_actual),
    .err_element(err_element), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_syndrome(rd_syndrome), .rd_element(rd_element),
    .log_count(log_count), .err_count(err_count),
    .fail_bitmap(fail_bitmap), .first_fail_valid(first_fail_valid),
    .first_fail_addr(first_fail_addr), .overflow(overflow)
  );

  bist_fail_logger #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .session_start(session_start),
    .err_valid(err_valid), .err_addr(err_addr),
    .err_expected(err_expected), .err_actual(err_actual),
    .err_element(err_element), .rd_valid(rd_valid_4),
    .rd_ready(rd_ready), .rd_addr(rd_addr_4),
    .rd_syndrome(rd_syndrome_4), .rd_element(rd_element_4),
    .log_count(log_count_4), .err_count(err_count_4),
    .fail_bitmap(fail_bitmap_4), .first_fail_valid(first_fail_valid_4),
    .first_fail_addr(first_fail_addr_4), .overflow(overflow_4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    session_start = 1'b1;
    step();
    session_start = 1'b0;
  endtask

  task automatic ev(input logic [9:0] a, input logic [31:0] e,
                    input logic [31:0] r, input logic [3:0] el);
    err_valid    = 1'b1;
    err_addr     = a;
    err_expected = e;
    err_actual   = r;
    err_element  = el;
    step();
    err_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; session_start = 1'b0; err_valid = 1'b0;
    err_addr = '0; err_expected = '0; err_actual = '0;
    err_element = '0; rd_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_rd_valid", rd_valid, 0);
    check("rst_log_count", log_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bitmap", fail_bitmap, 0);
    check("rst_ffv", first_fail_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dut.state_q, CLEAR);
    step();
    check("armed_state", dut.state_q, ARMED);

    // single event
    ev(10'h005, 32'h0, 32'h10, 4'd1);
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_addr", rd_addr, 10'h005);
    check("t1_rd_syn", rd_syndrome, 32'h10);
    check("t1_rd_elem", rd_element, 1);
    check("t1_err_count", err_count, 1);
    check("t1_ffa", first_fail_addr, 10'h005);
    check("t1_bitmap", fail_bitmap, 32'h10);
    check("t1_state", dut.state_q, LOGGING);

    // overflow: 10 events into depth 8
    clear();
    for (int i = 0; i < 10; i++) begin
      err_valid = 1'b1; err_addr = 10'h010 + 10'(i);
      err_expected = '0; err_actual = 32'h1 << i; err_element = 4'd2;
      step();
    end
    err_valid = 1'b0;
    check("t2_log_count", log_count, 8);
    check("t2_overflow", overflow, 1);
    check("t2_err_count", err_count, 10);
    check("t2_bitmap", fail_bitmap, 32'h3FF);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_drain%0d", i), rd_addr, 10'h010 + 10'(i));
      step();
    end
    rd_ready = 1'b0;
    check("t2_empty", rd_valid, 0);

    // full, then simultaneous push and pop
    clear();
    for (int i = 0; i < 8; i++) begin
      err_valid = 1'b1; err_addr = 10'h020 + 10'(i);
      err_expected = '0; err_actual = 32'h4; err_element = 4'd3;
      step();
    end
    err_valid = 1'b0;
    check("t3_full", log_count, 8);
    rd_ready = 1'b1;
    ev(10'h02A, 32'h0, 32'h8, 4'd5);
    rd_ready = 1'b0;
    check("t3_count", log_count, 8);
    check("t3_overflow", overflow, 0);
    check("t3_head", rd_addr, 10'h021);
    rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("t3_last_addr", rd_addr, 10'h02A);
    check("t3_last_syn", rd_syndrome, 32'h8);
    check("t3_last_elem", rd_element, 5);
    step();
    rd_ready = 1'b0;
    check("t3_empty", rd_valid, 0);

    // bitmap accumulation
    clear();
    ev(10'h031, 32'h0, 32'h1, 4'd0);
    ev(10'h032, 32'h100, 32'h0, 4'd0);
    ev(10'h033, 32'h1, 32'h0, 4'd0);
    check("t4_bitmap", fail_bitmap, 32'h101);
    check("t4_ffa", first_fail_addr, 10'h031);
    check("t4_ffv", first_fail_valid, 1);
    check("t4_count", log_count, 3);

    // session_start wins over a same-cycle event
    session_start = 1'b1;
    ev(10'h040, 32'h0, 32'hF, 4'd6);
    session_start = 1'b0;
    check("t5_rd_valid", rd_valid, 0);
    check("t5_count", log_count, 0);
    check("t5_err_count", err_count, 0);
    check("t5_bitmap", fail_bitmap, 0);
    check("t5_ffv", first_fail_valid, 0);
    check("t5_ffa", first_fail_addr, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_state", dut.state_q, CLEAR);

    // saturation on the narrow counter
    for (int i = 0; i < 20; i++) begin
      err_valid = 1'b1; err_addr = 10'(i);
      err_expected = '0; err_actual = 32'h2; err_element = 4'd7;
      step();
    end
    err_valid = 1'b0;
    check("t6_cnt4", err_count_4, 4'hF);
    check("t6_state4", dut4.state_q, SATURATED);
    check("t6_cnt16", err_count, 20);
    check("t6_state16", dut.state_q, LOGGING);
    check("t6_bitmap4", fail_bitmap_4, 32'h2);

    // repeated address/element
    clear();
    ev(10'h3FF, 32'h0, 32'h1, 4'd4);
    ev(10'h3FF, 32'h0, 32'h2, 4'd4);
    check("t7_err_count", err_count, 2);
    check("t7_bitmap", fail_bitmap, 32'h3);
`ifdef FAIL_LOG_DEDUP_EN
    check("t7_log_count", log_count, 1);
`else
    check("t7_log_count", log_count, 2);
`endif

    // reset during readout
    rd_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_ready = 1'b0;
    check("t8_rd_valid", rd_valid, 0);
    check("t8_count", log_count, 0);
    check("t8_err_count", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
